// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bus between the memory stage and its RAM.
// The memory stage drives requests; the RAM returns registered read data.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        data_sram_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, data_sram_rvalid, data_sram_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, data_sram_rvalid, data_sram_err
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data RAM with byte-lane writes and a fixed-latency
// registered read pipeline carrying {valid, err, data}.
module data_sram_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  bus
);
  localparam int L = READ_LATENCY;

  logic [31:0]          r_mem [2**ADDR_BITS];
  logic [L-1:0]         r_vld_p;
  logic [L-1:0]         r_err_p;
  logic [31:0]          r_data_p [L];

  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_oor;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_unused_lsb;

  assign w_idx        = bus.data_sram_addr[ADDR_BITS+1:2];
  assign w_oor        = |bus.data_sram_addr[31:ADDR_BITS+2];
  assign w_rd         = bus.data_sram_en & (bus.data_sram_wen == 4'b0000);
  // Writes are gated by resetn so a request held during reset never lands.
  assign w_wr         = resetn & bus.data_sram_en & (|bus.data_sram_wen) & ~w_oor;
  assign w_unused_lsb = ^bus.data_sram_addr[1:0];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage p0 samples the array at the request edge; later stages just shift.
  always_ff @(posedge clk) begin
    r_data_p[0] <= (w_rd && !w_oor) ? r_mem[w_idx] : 32'h0;
    for (int i = 1; i < L; i++) begin
      r_data_p[i] <= r_data_p[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p <= '0;
      r_err_p <= '0;
    end else begin
      r_vld_p[0] <= w_rd;
      r_err_p[0] <= bus.data_sram_en & w_oor;
      for (int i = 1; i < L; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_err_p[i] <= r_err_p[i-1];
      end
    end
  end

  // Output slot: data is forced to zero whenever the slot carries no read.
  assign bus.data_sram_rvalid = r_vld_p[L-1];
  assign bus.data_sram_err    = r_err_p[L-1];
  assign bus.data_sram_rdata  = r_vld_p[L-1] ? r_data_p[L-1] : 32'h0;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench: three responders (latency 1, 3 and 4) share clock and reset.
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_sram_responder_if b1 ();
  data_sram_responder_if b3 ();
  data_sram_responder_if b4 ();

  data_sram_responder #(.ADDR_BITS(10), .READ_LATENCY(1)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  data_sram_responder #(.ADDR_BITS(10), .READ_LATENCY(3)) u3 (.clk(clk), .resetn(resetn), .bus(b3));
  data_sram_responder #(.ADDR_BITS(10), .READ_LATENCY(4)) u4 (.clk(clk), .resetn(resetn), .bus(b4));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.data_sram_en = 1'b0; b1.data_sram_wen = 4'h0; b1.data_sram_addr = '0; b1.data_sram_wdata = '0;
    b3.data_sram_en = 1'b0; b3.data_sram_wen = 4'h0; b3.data_sram_addr = '0; b3.data_sram_wdata = '0;
    b4.data_sram_en = 1'b0; b4.data_sram_wen = 4'h0; b4.data_sram_addr = '0; b4.data_sram_wdata = '0;
  endtask

  task automatic req1(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    b1.data_sram_en = en; b1.data_sram_wen = wen; b1.data_sram_addr = addr; b1.data_sram_wdata = wd;
  endtask

  task automatic req3(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    b3.data_sram_en = en; b3.data_sram_wen = wen; b3.data_sram_addr = addr; b3.data_sram_wdata = wd;
  endtask

  task automatic req4(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
    b4.data_sram_en = en; b4.data_sram_wen = wen; b4.data_sram_addr = addr; b4.data_sram_wdata = wd;
  endtask

  task automatic test_reset();
    req1(1'b1, 4'hF, 32'h0, 32'hDEADBEEF);
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++;
      if ({b1.data_sram_rdata, b1.data_sram_rvalid, b1.data_sram_err} !== 34'h0) begin
        bad++;
        $display("FAIL reset_outputs cycle %0d: rdata=%h rvalid=%b err=%b, required 0/0/0",
                 c, b1.data_sram_rdata, b1.data_sram_rvalid, b1.data_sram_err);
      end
    end
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;
    cyc();
    req1(1'b1, 4'h0, 32'h0, 32'h0);
    cyc();
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (b1.data_sram_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_read_rvalid: rvalid=%b, required 1", b1.data_sram_rvalid);
    end
    total++;
    if (b1.data_sram_rdata === 32'hDEADBEEF) begin
      bad++;
      $display("FAIL reset_no_write: rdata=%h, required anything but deadbeef", b1.data_sram_rdata);
    end
  endtask

  task automatic test_full_rw();
    req1(1'b1, 4'hF, 32'h100, 32'h12345678);
    cyc();
    total++;
    if (b1.data_sram_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL write_no_rvalid: rvalid=%b, required 0", b1.data_sram_rvalid);
    end
    req1(1'b1, 4'h0, 32'h100, 32'h0);
    cyc();
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (b1.data_sram_rvalid !== 1'b1 || b1.data_sram_rdata !== 32'h12345678 || b1.data_sram_err !== 1'b0) begin
      bad++;
      $display("FAIL full_rw: rvalid=%b rdata=%h err=%b, required 1/12345678/0",
               b1.data_sram_rvalid, b1.data_sram_rdata, b1.data_sram_err);
    end
    cyc();
    total++;
    if (b1.data_sram_rvalid !== 1'b0 || b1.data_sram_rdata !== 32'h0) begin
      bad++;
      $display("FAIL idle_slot: rvalid=%b rdata=%h, required 0/00000000", b1.data_sram_rvalid, b1.data_sram_rdata);
    end
  endtask

  task automatic test_byte_lanes();
    req1(1'b1, 4'b0100, 32'h102, 32'h00AB0000);
    cyc();
    req1(1'b1, 4'h0, 32'h100, 32'h0);
    cyc();
    total++;
    if (b1.data_sram_rdata !== 32'h12AB5678) begin
      bad++;
      $display("FAIL byte_lane2: rdata=%h, required 12ab5678", b1.data_sram_rdata);
    end
    req1(1'b1, 4'b1001, 32'h101, 32'hCD0000EF);
    cyc();
    req1(1'b1, 4'h0, 32'h100, 32'h0);
    cyc();
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (b1.data_sram_rdata !== 32'hCDAB56EF) begin
      bad++;
      $display("FAIL byte_lanes30: rdata=%h, required cdab56ef", b1.data_sram_rdata);
    end
  endtask

  task automatic test_out_of_range();
    req1(1'b1, 4'hF, 32'h0, 32'hA5A5A5A5);
    cyc();
    req1(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF);
    cyc();
    total++;
    if (b1.data_sram_err !== 1'b1 || b1.data_sram_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL oor_write: err=%b rvalid=%b, required 1/0", b1.data_sram_err, b1.data_sram_rvalid);
    end
    req1(1'b1, 4'h0, 32'h1000, 32'h0);
    cyc();
    total++;
    if (b1.data_sram_err !== 1'b1 || b1.data_sram_rvalid !== 1'b1 || b1.data_sram_rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_read: err=%b rvalid=%b rdata=%h, required 1/1/00000000",
               b1.data_sram_err, b1.data_sram_rvalid, b1.data_sram_rdata);
    end
    req1(1'b1, 4'h0, 32'h0, 32'h0);
    cyc();
    total++;
    if (b1.data_sram_rdata !== 32'hA5A5A5A5 || b1.data_sram_err !== 1'b0) begin
      bad++;
      $display("FAIL oor_word0_kept: rdata=%h err=%b, required a5a5a5a5/0", b1.data_sram_rdata, b1.data_sram_err);
    end
    req1(1'b1, 4'h0, 32'h80000000, 32'h0);
    cyc();
    req1(1'b0, 4'h0, 32'h0, 32'h0);
    total++;
    if (b1.data_sram_err !== 1'b1 || b1.data_sram_rdata !== 32'h0) begin
      bad++;
      $display("FAIL oor_msb: err=%b rdata=%h, required 1/00000000", b1.data_sram_err, b1.data_sram_rdata);
    end
    cyc();
    total++;
    if (b1.data_sram_err !== 1'b0) begin
      bad++;
      $display("FAIL err_single_pulse: err=%b, required 0", b1.data_sram_err);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [31:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      req3(1'b1, 4'hF, 32'(4 * k), 32'(k + 1));
      cyc();
    end
    for (int j = 0; j < 7; j++) begin
      if (j < 4) req3(1'b1, 4'h0, 32'(4 * j), 32'h0);
      else       req3(1'b0, 4'h0, 32'h0, 32'h0);
      cyc();
      exp_v = (j >= 2 && j <= 5);
      exp_d = exp_v ? 32'(j - 1) : 32'h0;
      total++;
      if (b3.data_sram_rvalid !== exp_v || b3.data_sram_rdata !== exp_d) begin
        bad++;
        $display("FAIL stream cycle %0d: rvalid=%b rdata=%h, required %b/%h",
                 j, b3.data_sram_rvalid, b3.data_sram_rdata, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_midflight_reset();
    req4(1'b1, 4'hF, 32'h8, 32'h00000055);
    cyc();
    req4(1'b1, 4'h0, 32'h8, 32'h0);
    cyc();
    req4(1'b0, 4'h0, 32'h0, 32'h0);
    cyc();
    resetn = 1'b0;
    #1;
    total++;
    if (b4.data_sram_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: rvalid=%b, required 0", b4.data_sram_rvalid);
    end
    cyc();
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      total++;
      if (b4.data_sram_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL midflight_dropped cycle %0d: rvalid=%b, required 0", c, b4.data_sram_rvalid);
      end
    end
    req4(1'b1, 4'h0, 32'h8, 32'h0);
    for (int j = 0; j < 5; j++) begin
      cyc();
      req4(1'b0, 4'h0, 32'h0, 32'h0);
      total++;
      if (b4.data_sram_rvalid !== (j == 3) || b4.data_sram_rdata !== ((j == 3) ? 32'h55 : 32'h0)) begin
        bad++;
        $display("FAIL lat4_read cycle %0d: rvalid=%b rdata=%h, required %b/%h",
                 j, b4.data_sram_rvalid, b4.data_sram_rdata, (j == 3), ((j == 3) ? 32'h55 : 32'h0));
      end
    end
  endtask

  initial begin
    idle_all();
    resetn = 1'b0;
    cyc();
    test_reset();
    test_full_rw();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_midflight_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
